mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the MIPS pipeline, sitting after the execute stage and before register writeback. It accepts one execute-stage result per transaction: either a plain ALU result to forward, or an effective address plus store data for LW/LB/LBU/SW/SB. For memory operations it runs a request/acknowledge handshake with data memory and stalls upstream while the access is outstanding. Bit ordering is big-endian throughout: bit 0 is the MSB, and byte 0 is bits [0:7].

## Interface
- No parameters. Address and data are fixed at 32 bits.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  execute result present this cycle.
- alu_result  in  [0:31]  ALU result or effective address.
- store_data  in  [0:31]  rt value for stores.
- mem_op  in  [0:2]  operation select:
  - 000 none; 001 LW; 010 LB; 011 LBU; 100 SW; 101 SB.
  - 110 and 111 are illegal and are handled as none.
- dest_reg  in  [0:4]  writeback register number.
- stall  out  1  high while busy; new valid_in is ignored.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  [0:31]  word address; bits [30:31] are forced to 00.
- dmem_wdata  out  [0:31]  write data.
- dmem_be  out  [0:3]  byte enables; be[0] is byte 0 (bits [0:7]).
- dmem_ack  in  1  memory completion; read data is valid in the same cycle.
- dmem_rdata  in  [0:31]  read data.
- wb_valid  out  1  one-cycle pulse: writeback slot valid.
- wb_we  out  1  register write enable, qualified by wb_valid.
- wb_reg  out  [0:4]  destination register.
- wb_data  out  [0:31]  writeback data.
- misaligned  out  1  one-cycle pulse: LW/SW address with bits [30:31] != 00.

## Operation
- States: IDLE and ACCESS. Reset puts the block in IDLE with every output at 0.
- IDLE, valid_in=1, op none or illegal:
  - Next cycle: wb_valid=1, wb_data=alu_result, wb_reg=dest_reg.
  - wb_we=1 unless dest_reg==0.
- IDLE, valid_in=1, LW or SW with alu_result[30:31]!=00:
  - Next cycle: misaligned=1, wb_valid=1, wb_we=0.
  - No memory request is issued.
- IDLE, valid_in=1, any other load or store:
  - Latch op, address offset, dest_reg and store data; go to ACCESS.
  - dmem_req=1 from the next cycle.
  - dmem_addr={alu_result[0:29],2'b00}.
- Write data and byte enables:
  - SW: dmem_we=1, dmem_be=1111, dmem_wdata=store_data.
  - SB: dmem_we=1, dmem_be is one-hot at byte index alu_result[30:31], dmem_wdata is store_data[24:31] replicated into all four bytes.
  - Loads: dmem_we=0, dmem_be=1111.
- ACCESS: stall=1, and dmem_req/we/addr/wdata/be are held stable until dmem_ack is sampled high.
- On the ack edge: the state returns to IDLE, dmem_req drops, and one cycle later wb_valid=1.
- Load data selection (byte index k = latched offset):
  - LW: wb_data=dmem_rdata.
  - LB: byte k of dmem_rdata, sign-extended.
  - LBU: byte k of dmem_rdata, zero-extended.
  - wb_we=1 unless dest_reg==0.
- Stores: wb_valid=1, wb_we=0, wb_data=0.
- Ignored inputs:
  - dmem_ack outside ACCESS.
  - valid_in while stall=1. The upstream stage must hold its result.
- Reset mid-access drops dmem_req immediately. The outstanding access is abandoned and produces no writeback pulse.

## Timing
- stall = (state==ACCESS). It is a combinational output of the state register.
- Pass-through and misaligned operations: 1-cycle latency from valid_in to wb_valid. No stall is asserted.
- Memory operations:
  - dmem_req rises 1 cycle after accept.
  - An ack on that first req cycle is legal: minimum 2-cycle latency from accept to wb_valid.
  - Total latency is 2 cycles + ack wait.
- IDLE→IDLE back-to-back pass-through accepts every cycle, so wb_valid can stay high on consecutive cycles.
- After an ack, a new valid_in is accepted on the cycle after the ack edge, because stall is then low.
- wb_* and misaligned are registered, and all single-cycle pulses return to 0 afterwards. wb_data/wb_reg keep their last values.

## Test plan
- Pass-through:
  - Stimulus: mem_op=000, alu_result=0x0000_1234, dest_reg=5.
  - Required: next cycle wb_valid=1, wb_we=1, wb_reg=5, wb_data=0x0000_1234, with stall never high.
- LB with a wait state:
  - Stimulus: addr=0x103, memory acks after 3 req cycles with rdata=0x1122_33F0.
  - Required: dmem_addr=0x100 and stall high for exactly 3 cycles; then wb_data=0xFFFF_FFF0.
  - Same stimulus as LBU: wb_data=0x0000_00F0.
- SB:
  - Stimulus: addr=0x201, store_data=0xAABB_CCDD.
  - Required: dmem_be=0100, dmem_wdata=0xDDDD_DDDD, dmem_we=1, with outputs held stable until ack; then wb_valid=1 with wb_we=0.
- Misaligned LW:
  - Stimulus: addr=0x102.
  - Required: misaligned pulse, wb_valid=1 with wb_we=0, and dmem_req never asserted.
- Writes to register 0:
  - Stimulus: LW to dest_reg=0 with rdata=0xDEAD_BEEF.
  - Required: wb_valid=1, wb_we=0.
- Reset and back-to-back traffic:
  - Stimulus: assert reset_n=0 during ACCESS.
  - Required: dmem_req, stall and wb_valid are 0 immediately, and no writeback occurs after release.
  - Then: after an ack edge, a valid_in presented on the following cycle is accepted.

Source files
------------

// File: rtl/mem_access.sv
// MIPS memory-access stage: forwards ALU results or runs a req/ack data-memory
// access for LW/LB/LBU/SW/SB, stalling upstream while the access is outstanding.
module mem_access (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        valid_in,
    input  logic [0:31] alu_result,
    input  logic [0:31] store_data,
    input  logic [0:2]  mem_op,
    input  logic [0:4]  dest_reg,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [0:31] dmem_addr,
    output logic [0:31] dmem_wdata,
    output logic [0:3]  dmem_be,
    input  logic        dmem_ack,
    input  logic [0:31] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [0:4]  wb_reg,
    output logic [0:31] wb_data,
    output logic        misaligned
);

    localparam logic [0:2] OP_LW  = 3'b001;
    localparam logic [0:2] OP_LB  = 3'b010;
    localparam logic [0:2] OP_LBU = 3'b011;
    localparam logic [0:2] OP_SW  = 3'b100;
    localparam logic [0:2] OP_SB  = 3'b101;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t      state_r;
    logic [0:2]  op_r;
    logic [0:1]  offset_r;
    logic [0:4]  dest_r;
    logic        is_mem_s;
    logic        is_store_s;
    logic        misalign_s;

    // Big-endian byte k of a word: byte 0 is the most significant byte.
    function automatic logic [0:7] byte_sel(input logic [0:31] word, input logic [0:1] k);
        case (k)
            2'd0:    byte_sel = word[0:7];
            2'd1:    byte_sel = word[8:15];
            2'd2:    byte_sel = word[16:23];
            default: byte_sel = word[24:31];
        endcase
    endfunction

    function automatic logic [0:31] load_data(input logic [0:2] op, input logic [0:1] k,
                                              input logic [0:31] word);
        logic [0:7] b;
        b = byte_sel(word, k);
        case (op)
            OP_LB:   load_data = {{24{b[0]}}, b};
            OP_LBU:  load_data = {24'd0, b};
            default: load_data = word;
        endcase
    endfunction

    function automatic logic [0:3] byte_enable(input logic [0:1] k);
        case (k)
            2'd0:    byte_enable = 4'b1000;
            2'd1:    byte_enable = 4'b0100;
            2'd2:    byte_enable = 4'b0010;
            default: byte_enable = 4'b0001;
        endcase
    endfunction

    assign stall = (state_r == ST_ACCESS);

    // Classify the incoming operation; illegal encodings fall through as pass-through.
    always_comb begin
        is_mem_s   = 1'b0;
        is_store_s = 1'b0;
        misalign_s = 1'b0;
        case (mem_op)
            OP_LW, OP_LB, OP_LBU: is_mem_s = 1'b1;
            OP_SW, OP_SB: begin
                is_mem_s   = 1'b1;
                is_store_s = 1'b1;
            end
            default: is_mem_s = 1'b0;
        endcase
        if ((mem_op == OP_LW || mem_op == OP_SW) && alu_result[30:31] != 2'b00) begin
            misalign_s = 1'b1;
        end else begin
            misalign_s = 1'b0;
        end
    end

    // Stage FSM with registered memory request and writeback outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            op_r       <= 3'b000;
            offset_r   <= 2'b00;
            dest_r     <= 5'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            dmem_be    <= 4'b0000;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_reg     <= 5'd0;
            wb_data    <= 32'd0;
            misaligned <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            misaligned <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (valid_in && misalign_s) begin
                        misaligned <= 1'b1;
                        wb_valid   <= 1'b1;
                        wb_reg     <= dest_reg;
                        wb_data    <= 32'd0;
                    end else if (valid_in && is_mem_s) begin
                        state_r   <= ST_ACCESS;
                        op_r      <= mem_op;
                        offset_r  <= alu_result[30:31];
                        dest_r    <= dest_reg;
                        dmem_req  <= 1'b1;
                        dmem_we   <= is_store_s;
                        dmem_addr <= {alu_result[0:29], 2'b00};
                        if (mem_op == OP_SB) begin
                            dmem_be    <= byte_enable(alu_result[30:31]);
                            dmem_wdata <= {4{store_data[24:31]}};
                        end else begin
                            dmem_be    <= 4'b1111;
                            dmem_wdata <= is_store_s ? store_data : 32'd0;
                        end
                    end else if (valid_in) begin
                        wb_valid <= 1'b1;
                        wb_we    <= (dest_reg != 5'd0);
                        wb_reg   <= dest_reg;
                        wb_data  <= alu_result;
                    end
                end
                ST_ACCESS: begin
                    // Request fields stay frozen until the ack is sampled.
                    if (dmem_ack) begin
                        state_r  <= ST_IDLE;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_reg   <= dest_r;
                        if (op_r == OP_SW || op_r == OP_SB) begin
                            wb_we   <= 1'b0;
                            wb_data <= 32'd0;
                        end else begin
                            wb_we   <= (dest_r != 5'd0);
                            wb_data <= load_data(op_r, offset_r, dmem_rdata);
                        end
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected writebacks, a
// negedge monitor pops and compares every wb_valid pulse.
module tb_mem_access;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] alu_result = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic [2:0]  mem_op = 3'd0;
    logic [4:0]  dest_reg = 5'd0;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        misaligned;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [4:0]  rg;
        logic [31:0] data;
        logic        chk_data;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    mem_access dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .valid_in   (valid_in),
        .alu_result (alu_result),
        .store_data (store_data),
        .mem_op     (mem_op),
        .dest_reg   (dest_reg),
        .stall      (stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .misaligned (misaligned)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_wb(input logic we, input logic [4:0] rg, input logic [31:0] data,
                             input logic chk_data, input logic mis);
        exp_t e;
        e.we = we;
        e.rg = rg;
        e.data = data;
        e.chk_data = chk_data;
        e.mis = mis;
        sb.push_back(e);
    endtask

    // Monitor: every writeback pulse must match the oldest expected entry.
    always @(negedge clock) begin
        if (reset_n && wb_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_wb", 32'(wb_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_we", 32'(wb_we), 32'(e.we));
                chk("wb_reg", 32'(wb_reg), 32'(e.rg));
                if (e.chk_data) chk("wb_data", wb_data, e.data);
                chk("misaligned", 32'(misaligned), 32'(e.mis));
            end
        end else if (reset_n && misaligned) begin
            chk("stray_misaligned", 32'(misaligned), 32'd0);
        end
    end

    // Present one transaction for a single cycle, starting on a negedge.
    task automatic drive(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] dreg);
        valid_in = 1'b1;
        mem_op = op;
        alu_result = addr;
        store_data = sd;
        dest_reg = dreg;
        @(negedge clock);
        valid_in = 1'b0;
    endtask

    task automatic mem_txn(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [4:0] dreg,
                           input logic [31:0] rdata, input int waits,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input bit poke);
        int stalls;
        logic exp_we;
        stalls = 0;
        exp_we = (op == 3'b100 || op == 3'b101);
        drive(op, addr, sd, dreg);
        for (int i = 1; i <= waits; i++) begin
            chk({tag, "_req"}, 32'(dmem_req), 32'd1);
            chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
            chk({tag, "_we"}, 32'(dmem_we), 32'(exp_we));
            chk({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
            if (exp_we) chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
            if (stall) stalls++;
            if (poke && i == 1) begin
                valid_in = 1'b1;
                mem_op = 3'b000;
                dest_reg = 5'd7;
                alu_result = 32'h0000_5555;
            end
            if (i == waits) begin
                dmem_ack = 1'b1;
                dmem_rdata = rdata;
            end
            @(negedge clock);
            valid_in = 1'b0;
            dmem_ack = 1'b0;
            dmem_rdata = 32'd0;
        end
        chk({tag, "_stall_after"}, 32'(stall), 32'd0);
        chk({tag, "_req_after"}, 32'(dmem_req), 32'd0);
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(waits));
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Pass-through and back-to-back pass-through (incl. reg 0 and illegal op)
        expect_wb(1'b1, 5'd5, 32'h0000_1234, 1'b1, 1'b0);
        drive(3'b000, 32'h0000_1234, 32'd0, 5'd5);
        chk("pt_stall", 32'(stall), 32'd0);
        expect_wb(1'b1, 5'd9, 32'h0000_000A, 1'b1, 1'b0);
        drive(3'b000, 32'h0000_000A, 32'd0, 5'd9);
        expect_wb(1'b0, 5'd0, 32'h0000_000B, 1'b1, 1'b0);
        drive(3'b000, 32'h0000_000B, 32'd0, 5'd0);
        expect_wb(1'b1, 5'd12, 32'h0000_000C, 1'b1, 1'b0);
        drive(3'b110, 32'h0000_000C, 32'd0, 5'd12);
        chk("b2b_stall", 32'(stall), 32'd0);
        @(negedge clock);

        // LB with 3 wait cycles, plus a valid_in poke that must be ignored
        expect_wb(1'b1, 5'd4, 32'hFFFF_FFF0, 1'b1, 1'b0);
        mem_txn("lb", 3'b010, 32'h0000_0103, 32'd0, 5'd4, 32'h1122_33F0, 3, 4'b1111, 32'd0, 1'b1);
        @(negedge clock);

        expect_wb(1'b1, 5'd4, 32'h0000_00F0, 1'b1, 1'b0);
        mem_txn("lbu", 3'b011, 32'h0000_0103, 32'd0, 5'd4, 32'h1122_33F0, 3, 4'b1111, 32'd0, 1'b0);
        // Accept on the cycle right after the ack edge
        expect_wb(1'b1, 5'd6, 32'h0000_CAFE, 1'b1, 1'b0);
        drive(3'b000, 32'h0000_CAFE, 32'd0, 5'd6);
        chk("post_ack_stall", 32'(stall), 32'd0);

        expect_wb(1'b0, 5'd2, 32'd0, 1'b1, 1'b0);
        mem_txn("sb", 3'b101, 32'h0000_0201, 32'hAABB_CCDD, 5'd2, 32'd0, 2, 4'b0100, 32'hDDDD_DDDD, 1'b0);

        // SW acked on the first request cycle
        expect_wb(1'b0, 5'd3, 32'd0, 1'b1, 1'b0);
        mem_txn("sw", 3'b100, 32'h0000_0300, 32'h1234_5678, 5'd3, 32'd0, 1, 4'b1111, 32'h1234_5678, 1'b0);

        expect_wb(1'b0, 5'd8, 32'd0, 1'b0, 1'b1);
        drive(3'b001, 32'h0000_0102, 32'd0, 5'd8);
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_stall", 32'(stall), 32'd0);
        @(negedge clock);
        chk("mis_req_later", 32'(dmem_req), 32'd0);

        expect_wb(1'b0, 5'd0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        mem_txn("lw_r0", 3'b001, 32'h0000_0040, 32'd0, 5'd0, 32'hDEAD_BEEF, 2, 4'b1111, 32'd0, 1'b0);

        // Ack while idle must be ignored
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0BAD_0BAD;
        @(negedge clock);
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        chk("idle_ack_stall", 32'(stall), 32'd0);
        chk("idle_ack_req", 32'(dmem_req), 32'd0);

        // Reset in the middle of an access abandons it
        drive(3'b001, 32'h0000_0400, 32'd0, 5'd3);
        chk("rst_mid_req_before", 32'(dmem_req), 32'd1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_req", 32'(dmem_req), 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_after_req", 32'(dmem_req), 32'd0);
        chk("rst_after_stall", 32'(stall), 32'd0);

        expect_wb(1'b1, 5'd31, 32'h7777_0001, 1'b1, 1'b0);
        drive(3'b000, 32'h7777_0001, 32'd0, 5'd31);
        repeat (2) @(negedge clock);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
